aes_block_mem_ctrl: RTL and testbench
=====================================

# aes_block_mem_ctrl

Block-transfer controller that shares the byte-wide 256-byte scratch memory between two requesters (0: AES core, 1: host loader). It moves one 128-bit AES block per request, as 16 consecutive byte accesses, either from a requester into memory or from memory back to it. It arbitrates round-robin, sequences the memory's 1-cycle synchronous read, and signals completion with a one-cycle done pulse. It sits between the AES datapath/host and the memory instance.

## Interface

- No parameters; block size is fixed at 16 bytes and memory depth at 256 bytes.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: transfer request, level, one per requester.
- `op0`, `op1` in 1: operation select; 0 = read block from memory, 1 = write block to memory.
- `base0`, `base1` in 8: byte address of block byte 0.
- `wdata0`, `wdata1` in 128: block to write; byte k = bits [127-8k -: 8].
- `rdata` out 128: last block read, same byte order; shared by both requesters.
- `done0`, `done1` out 1: one-cycle completion pulse for each requester.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `owner` out 1: index of the current or last granted requester.
- `mem_addr` out 8, `mem_wr` out 1, `mem_wdata` out 8: memory port outputs.
- `mem_rdata` in 8: memory read data, valid the cycle after the address is presented with `mem_wr`=0.

## Operation

- **Reset values:**
  - state = IDLE.
  - `rdata` = 0; `done0`/`done1`/`busy` = 0.
  - `owner` = 1, so requester 0 wins the first contest.
  - `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0; byte counter = 0.
- **FSM states:** IDLE, WR, RD, RDLAST, DONE.
- **IDLE:** `mem_wr` = 0.
  - If any req is high, grant it.
  - If both are high, grant the requester ≠ `owner`.
  - On grant, latch op, base and wdata of the winner, set `owner`, clear the counter, and go to WR (op=1) or RD (op=0).
- **WR:** drive `mem_wr` = 1, `mem_addr` = base+cnt (mod 256), `mem_wdata` = byte cnt.
  - cnt increments every cycle.
  - After cnt=15, go to DONE.
- **RD:** drive `mem_wr` = 0, `mem_addr` = base+cnt (mod 256), for cnt 0..15.
  - At each edge from the second RD cycle onward, capture `mem_rdata` into byte cnt-1 of `rdata`.
  - After cnt=15, go to RDLAST.
- **RDLAST:** capture byte 15, then go to DONE. `mem_wr` = 0.
- **DONE:** assert `done[owner]` = 1 for exactly this cycle, then go to IDLE.
- **Address arithmetic:** 8-bit wrap-around. Base 0xF8 covers 0xF8..0xFF, then 0x00..0x07.
- **Input sampling:** req/op/base/wdata are sampled only at grant. Changes while busy are ignored.
  - A request that arrives during a transfer waits.
  - Requesters must drop req in the cycle after seeing done, otherwise a new transfer is granted.
- **`rdata`:** updates only during reads and holds between transfers; writes never modify it.
- **Reset mid-operation:**
  - Immediate return to reset values; `mem_wr` drops asynchronously.
  - No done pulse.
  - Bytes already written remain in memory.

## Timing

- Grant cycle N is the IDLE cycle with req high.
- **Write:** WR occupies cycles N+1..N+16 (byte k written at the end of N+1+k); `done` is high in cycle N+17.
- **Read:** addresses are presented in N+1..N+16 and byte k is captured at the end of cycle N+2+k. `done` is high in N+18, with `rdata` complete in that cycle.
- **Back-to-back:** DONE → IDLE (1 cycle) → next grant. Minimum gap between two grants is 18 cycles for a write and 19 for a read.
- **`busy`:** high from N+1 through the DONE cycle inclusive.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- **Write then read-back:** req0 write, base 0x10, wdata 0x000102..0F; then req0 read, base 0x10.
  - `rdata` = 0x00010203_04050607_08090A0B_0C0D0E0F.
  - `done0` in cycles N+17 and N+18 respectively.
- **Wrap-around:** req1 write, base 0xF8.
  - `mem_addr` sequence is F8..FF, 00..07.
  - A read of base 0xF8 returns the same 128 bits.
- **Simultaneous requests after reset:** req0 and req1 both high.
  - Requester 0 is served first, then requester 1.
  - When both are requested again, requester 0 wins, because the last grant went to 1.
- **Uninitialized memory:** read of base 0x40 after memory reset → `rdata` = all 0xFF, `done` at N+18.
- **Reset mid-write:** assert `reset` after 5 bytes written.
  - `mem_wr` goes low immediately; `busy` = 0; no done pulse.
  - A subsequent read shows bytes 0..4 new and bytes 5..15 = 0xFF.
- **Request held through DONE / changed while busy:**
  - req held high through DONE → a second transfer starts.
  - base changed while busy → the address sequence is unaffected.

Source files
------------

// File: rtl/aes_block_mem_ctrl.sv
// rtl/aes_block_mem_ctrl.sv - round-robin 16-byte block mover between two requesters and a byte-wide scratch memory
module aes_block_mem_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [7:0]   base0,
  input  logic [7:0]   base1,
  input  logic [127:0] wdata0,
  input  logic [127:0] wdata1,
  output logic [127:0] rdata,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic         owner,
  output logic [7:0]   mem_addr,
  output logic         mem_wr,
  output logic [7:0]   mem_wdata,
  input  logic [7:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, RDLAST, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, cnt_nx, cnt_m1;
  logic [7:0]        base_q, base_d;
  // Element 15 holds block byte 0, so byte k lives at index ~k.
  logic [15:0][7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic              owner_q, owner_d, win;
  logic              done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  // Memory-port registers are loaded with the values for the state being entered,
  // so every output is a flop yet lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_nx      = cnt_q + 4'd1;
    cnt_m1      = cnt_q - 4'd1;
    win         = (req0 && req1) ? ~owner_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d    = win;
          cnt_d      = 4'd0;
          base_d     = win ? base1 : base0;
          wdata_d    = win ? wdata1 : wdata0;
          mem_addr_d = base_d;
          if (win ? op1 : op0) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = wdata_d[15];
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          cnt_d       = cnt_nx;
          mem_wr_d    = 1'b1;
          mem_addr_d  = base_q + {4'd0, cnt_nx};
          mem_wdata_d = wdata_q[~cnt_nx];
        end
      end
      RD: begin
        if (cnt_q != 4'd0) rdata_d[~cnt_m1] = mem_rdata;
        if (cnt_q == 4'd15) begin
          state_d = RDLAST;
        end else begin
          cnt_d      = cnt_nx;
          mem_addr_d = base_q + {4'd0, cnt_nx};
        end
      end
      RDLAST: begin
        rdata_d[0] = mem_rdata;
        state_d    = DONE;
        done0_d    = ~owner_q;
        done1_d    = owner_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      base_q      <= 8'd0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      owner_q     <= 1'b1;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_aes_block_mem_ctrl.sv
// tb/tb_aes_block_mem_ctrl.sv - randomized self-checking bench with scoreboard memory model
module tb_aes_block_mem_ctrl;

  logic         clk, reset, mem_clear;
  logic         req_v [2];
  logic         op_v [2];
  logic [7:0]   base_v [2];
  logic [127:0] wdata_v [2];
  logic [127:0] rdata;
  logic         done0, done1, busy, owner, mem_wr;
  logic [7:0]   mem_addr, mem_wdata, mem_rdata;

  logic [7:0]   mem [256];
  logic [7:0]   ref_mem [256];
  logic [127:0] exp_rdata;
  int           last_owner;
  int           n_tests, n_fail;

  aes_block_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .req1(req_v[1]), .op0(op_v[0]), .op1(op_v[1]),
    .base0(base_v[0]), .base1(base_v[1]), .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .rdata(rdata), .done0(done0), .done1(done1), .busy(busy), .owner(owner),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory instance: synchronous write, 1-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Follows one transfer of requester 'who' from grant to done, cycle by cycle.
  task automatic serve(input int who, input int exp_wait, input bit drop);
    int           w, last;
    bit           lop;
    logic [7:0]   lb;
    logic [127:0] ld;
    w = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (busy) begin
        w = i;
        break;
      end
    end
    check("grant_wait", 128'(w), 128'(exp_wait));
    if (w == 0) return;
    lop = op_v[who];
    lb  = base_v[who];
    ld  = wdata_v[who];
    check("owner", 128'(owner), 128'(who));
    base_v[who]  = 8'($urandom);
    wdata_v[who] = {$urandom, $urandom, $urandom, $urandom};
    last = lop ? 17 : 18;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      check("busy", 128'(busy), 128'(1));
      if (c <= 16) begin
        check("mem_addr", 128'(mem_addr), 128'(8'(lb + c - 1)));
        check("mem_wr", 128'(mem_wr), 128'(lop));
        if (lop) check("mem_wdata", 128'(mem_wdata), 128'(ld[127-8*(c-1) -: 8]));
      end
      if (c < last) check("done_early", 128'({done1, done0}), 128'(0));
    end
    check("done", 128'({done1, done0}), (who == 0) ? 128'(2'b01) : 128'(2'b10));
    if (lop) begin
      for (int k = 0; k < 16; k++) ref_mem[8'(lb + k)] = ld[127-8*k -: 8];
    end else begin
      for (int k = 0; k < 16; k++) exp_rdata[127-8*k -: 8] = ref_mem[8'(lb + k)];
    end
    check("rdata", rdata, exp_rdata);
    last_owner = who;
    if (drop) req_v[who] = 1'b0;
  endtask

  task automatic single(input int who, input bit op, input logic [7:0] b, input logic [127:0] d);
    req_v[who] = 1'b1; op_v[who] = op; base_v[who] = b; wdata_v[who] = d;
    serve(who, 1, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_owner = 1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int win, mask;
    logic [127:0] d;
    n_tests = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
    exp_rdata = '0; last_owner = 1;
    for (int r = 0; r < 2; r++) begin
      req_v[r] = 1'b0; op_v[r] = 1'b0; base_v[r] = 8'd0; wdata_v[r] = '0;
    end
    reset = 1'b1; mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, '0);
    check("rst_done", 128'({done1, done0}), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_owner", 128'(owner), 128'(1));
    check("rst_mem", 128'({mem_wr, mem_addr, mem_wdata}), 128'(0));
    mem_clear = 1'b0; reset = 1'b0;
    @(negedge clk);

    single(0, 1'b0, 8'h40, '0);
    check("uninit", rdata, {16{8'hFF}});

    single(0, 1'b1, 8'h10, 128'h000102030405060708090A0B0C0D0E0F);
    single(0, 1'b0, 8'h10, '0);
    check("readback", rdata, 128'h000102030405060708090A0B0C0D0E0F);

    d = {$urandom, $urandom, $urandom, $urandom};
    single(1, 1'b1, 8'hF8, d);
    single(1, 1'b0, 8'hF8, '0);
    check("wrap_readback", rdata, d);

    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 2; r++) begin
        req_v[r] = 1'b1; op_v[r] = r[0]; base_v[r] = 8'(8'h60 + 16 * r);
        wdata_v[r] = {$urandom, $urandom, $urandom, $urandom};
      end
      serve(0, 1, 1'b1);
      serve(1, 2, 1'b1);
      @(negedge clk);
    end

    req_v[0] = 1'b1; op_v[0] = 1'b1; base_v[0] = 8'h80;
    wdata_v[0] = {$urandom, $urandom, $urandom, $urandom};
    serve(0, 1, 1'b0);
    serve(0, 2, 1'b1);
    @(negedge clk);

    req_v[0] = 1'b1; op_v[0] = 1'b1; base_v[0] = 8'h20;
    wdata_v[0] = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("mw_wr", 128'(mem_wr), 128'(1));
    end
    req_v[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("mw_memwr", 128'(mem_wr), 128'(0));
    check("mw_busy", 128'(busy), 128'(0));
    check("mw_done", 128'({done1, done0}), 128'(0));
    for (int k = 0; k < 5; k++) ref_mem[8'(8'h20 + k)] = wdata_v[0][127-8*k -: 8];
    @(negedge clk);
    reset = 1'b0; last_owner = 1;
    repeat (2) begin
      @(negedge clk);
      check("mw_nodone", 128'({done1, done0, busy}), 128'(0));
    end
    single(0, 1'b0, 8'h20, '0);

    for (int it = 0; it < 14; it++) begin
      mask = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          req_v[r] = 1'b1; op_v[r] = 1'($urandom); base_v[r] = 8'($urandom);
          wdata_v[r] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (mask == 3) begin
        win = 1 - last_owner;
        serve(win, 1, 1'b1);
        serve(1 - win, 2, 1'b1);
      end else begin
        serve(mask - 1, 1, 1'b1);
      end
      @(negedge clk);
      single(int'($urandom_range(0, 1)), 1'b0, base_v[0], '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
